// File: rtl/sc_comp.sv
// Single-cycle MIPS-32 computer: core (U_SCPU), instruction ROM (U_IM), data RAM (U_DM).
// Define SCCOMP_HILO_EN to add HI/LO registers with mult/div/mfhi/mflo/mthi/mtlo.

module sccpu_rf (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  dbg_sel,
`ifdef SCCOMP_HILO_EN
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] hi_d,
    input  logic [31:0] lo_d,
    output logic [31:0] hi_val,
    output logic [31:0] lo_val,
`endif
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] dbg_data
);
    logic [31:0] rf [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we && (wa != 5'd0)) begin
            rf[wa] <= wd;
        end
    end

    assign rd1      = (ra1 == 5'd0)     ? 32'd0 : rf[ra1];
    assign rd2      = (ra2 == 5'd0)     ? 32'd0 : rf[ra2];
    assign dbg_data = (dbg_sel == 5'd0) ? 32'd0 : rf[dbg_sel];

`ifdef SCCOMP_HILO_EN
    logic [31:0] hi, lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we) hi <= hi_d;
            if (lo_we) lo <= lo_d;
        end
    end

    assign hi_val = hi;
    assign lo_val = lo;
`endif
endmodule

module sccpu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] dm_rdata,
    input  logic [4:0]  reg_sel,
    output logic [31:0] fetch_pc,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic        dm_we,
    output logic [31:0] reg_data
);
    logic [31:0] PC, npc, pc_plus4;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs_val, rt_val, imm_sext, imm_zext, branch_target, jump_target;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];
    assign idx   = instr[25:0];

    assign pc_plus4      = PC + 32'd4;
    assign imm_sext      = {{16{imm[15]}}, imm};
    assign imm_zext      = {16'd0, imm};
    assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], idx, 2'b00};

    // lw/sw address is always rs + sext(imm); only sw actually drives a write
    assign dm_addr  = rs_val + imm_sext;
    assign dm_wdata = rt_val;
    assign fetch_pc = PC;

`ifdef SCCOMP_HILO_EN
    logic        hi_we, lo_we;
    logic [31:0] hi_d, lo_d, hi_val, lo_val;
    logic [63:0] prod_s, prod_u;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;

    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    assign quot_s = $signed(rs_val) / $signed(rt_val);
    assign rem_s  = $signed(rs_val) % $signed(rt_val);
    assign quot_u = rs_val / rt_val;
    assign rem_u  = rs_val % rt_val;
`endif

    sccpu_rf U_RF (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .ra1      (rs),
        .ra2      (rt),
        .wa       (rf_wa),
        .wd       (rf_wd),
        .dbg_sel  (reg_sel),
`ifdef SCCOMP_HILO_EN
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .hi_d     (hi_d),
        .lo_d     (lo_d),
        .hi_val   (hi_val),
        .lo_val   (lo_val),
`endif
        .rd1      (rs_val),
        .rd2      (rt_val),
        .dbg_data (reg_data)
    );

    always_comb begin
        npc   = pc_plus4;
        rf_we = 1'b0;
        rf_wa = rd;
        rf_wd = 32'd0;
        dm_we = 1'b0;
`ifdef SCCOMP_HILO_EN
        hi_we = 1'b0;
        lo_we = 1'b0;
        hi_d  = 32'd0;
        lo_d  = 32'd0;
`endif
        case (op)
            6'h00: begin
                rf_we = 1'b1;
                case (funct)
                    6'h20, 6'h21: rf_wd = rs_val + rt_val;
                    6'h22, 6'h23: rf_wd = rs_val - rt_val;
                    6'h24: rf_wd = rs_val & rt_val;
                    6'h25: rf_wd = rs_val | rt_val;
                    6'h26: rf_wd = rs_val ^ rt_val;
                    6'h27: rf_wd = ~(rs_val | rt_val);
                    6'h2A: rf_wd = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    6'h2B: rf_wd = {31'd0, rs_val < rt_val};
                    6'h00: rf_wd = rt_val << shamt;
                    6'h02: rf_wd = rt_val >> shamt;
                    6'h03: rf_wd = $unsigned($signed(rt_val) >>> shamt);
                    6'h04: rf_wd = rt_val << rs_val[4:0];
                    6'h06: rf_wd = rt_val >> rs_val[4:0];
                    6'h07: rf_wd = $unsigned($signed(rt_val) >>> rs_val[4:0]);
                    6'h08: begin
                        rf_we = 1'b0;
                        npc   = rs_val;
                    end
                    6'h09: begin
                        rf_wd = pc_plus4;
                        npc   = rs_val;
                    end
`ifdef SCCOMP_HILO_EN
                    6'h10: rf_wd = hi_val;
                    6'h12: rf_wd = lo_val;
                    6'h11: begin
                        rf_we = 1'b0;
                        hi_we = 1'b1;
                        hi_d  = rs_val;
                    end
                    6'h13: begin
                        rf_we = 1'b0;
                        lo_we = 1'b1;
                        lo_d  = rs_val;
                    end
                    6'h18, 6'h19: begin
                        rf_we = 1'b0;
                        hi_we = 1'b1;
                        lo_we = 1'b1;
                        {hi_d, lo_d} = (funct == 6'h18) ? prod_s : prod_u;
                    end
                    6'h1A, 6'h1B: begin
                        // divide by zero leaves hi/lo untouched
                        rf_we = 1'b0;
                        hi_we = (rt_val != 32'd0);
                        lo_we = (rt_val != 32'd0);
                        hi_d  = (funct == 6'h1A) ? rem_s  : rem_u;
                        lo_d  = (funct == 6'h1A) ? quot_s : quot_u;
                    end
`endif
                    default: rf_we = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin rf_we = 1'b1; rf_wa = rt; rf_wd = rs_val + imm_sext; end
            6'h0A: begin rf_we = 1'b1; rf_wa = rt; rf_wd = {31'd0, $signed(rs_val) < $signed(imm_sext)}; end
            6'h0B: begin rf_we = 1'b1; rf_wa = rt; rf_wd = {31'd0, rs_val < imm_sext}; end
            6'h0C: begin rf_we = 1'b1; rf_wa = rt; rf_wd = rs_val & imm_zext; end
            6'h0D: begin rf_we = 1'b1; rf_wa = rt; rf_wd = rs_val | imm_zext; end
            6'h0E: begin rf_we = 1'b1; rf_wa = rt; rf_wd = rs_val ^ imm_zext; end
            6'h0F: begin rf_we = 1'b1; rf_wa = rt; rf_wd = {imm, 16'd0}; end
            6'h23: begin rf_we = 1'b1; rf_wa = rt; rf_wd = dm_rdata; end
            6'h2B: dm_we = 1'b1;
            6'h04: if (rs_val == rt_val) npc = branch_target;
            6'h05: if (rs_val != rt_val) npc = branch_target;
            6'h02: npc = jump_target;
            6'h03: begin
                npc   = jump_target;
                rf_we = 1'b1;
                rf_wa = 5'd31;
                rf_wd = pc_plus4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) PC <= 32'd0;
        else     PC <= npc;
    end
endmodule

module sccomp_im #(
    parameter int IM_DEPTH = 128
) (
    input  logic [6:0]  addr,
    output logic [31:0] dout
);
    // Contents are loaded from outside by the bench; no reset or write port.
    logic [31:0] ROM [0:IM_DEPTH-1];

    assign dout = ROM[addr];
endmodule

module sccomp_dm #(
    parameter int DM_DEPTH = 128
) (
    input  logic        clk,
    input  logic        we,
    input  logic [6:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout
);
    logic [31:0] RAM [0:DM_DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) RAM[addr] <= din;
    end

    assign dout = RAM[addr];
endmodule

module sc_comp #(
    parameter int IM_DEPTH = 128,
    parameter int DM_DEPTH = 128
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  reg_sel,
    output logic [31:0] reg_data
);
    logic [31:0] PC, instr, dm_addr, dm_wdata, dm_rdata;
    logic        dm_we;

    // rstn is an active-high synchronous reset despite its name
    sccpu U_SCPU (
        .clk      (clk),
        .rst      (rstn),
        .instr    (instr),
        .dm_rdata (dm_rdata),
        .reg_sel  (reg_sel),
        .fetch_pc (PC),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_we    (dm_we),
        .reg_data (reg_data)
    );

    sccomp_im #(.IM_DEPTH(IM_DEPTH)) U_IM (
        .addr (PC[8:2]),
        .dout (instr)
    );

    sccomp_dm #(.DM_DEPTH(DM_DEPTH)) U_DM (
        .clk  (clk),
        .we   (dm_we),
        .addr (dm_addr[8:2]),
        .din  (dm_wdata),
        .dout (dm_rdata)
    );

    // Memories are word-addressed through bits [8:2] only
    logic unused_bits;
    assign unused_bits = &{1'b0, PC[31:9], PC[1:0], dm_addr[31:9], dm_addr[1:0]};
endmodule

// File: tb/tb_sc_comp.sv
// Directed-program bench for sc_comp: each task loads a small hand-assembled program and checks results.

module tb_sc_comp;
    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic [31:0] prog [0:127];
    logic [31:0] v;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sc_comp dut (
        .clk      (clk),
        .rstn     (rstn),
        .reg_sel  (reg_sel),
        .reg_data (reg_data)
    );

    task clear_prog;
        for (int i = 0; i < 128; i++) prog[i] = 32'h0;
    endtask

    task load_prog;
        for (int i = 0; i < 128; i++) dut.U_IM.ROM[i] = prog[i];
    endtask

    task apply_reset;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
    endtask

    task run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task get_reg(input int r, output logic [31:0] val);
        reg_sel = 5'(r);
        #1;
        val = reg_data;
    endtask

    task test_reset;
        clear_prog();
        prog[0] = 32'h34011234;
        prog[1] = 32'h2022FFFC;
        load_prog();
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut.PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", dut.PC, 32'h0); end
        for (int r = 0; r < 32; r++) begin
            get_reg(r, v);
            checks++;
            if (v !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got %h expected %h", r, v, 32'h0); end
        end
        @(posedge clk);
        #1;
        rstn = 1'b0;
        checks++;
        if (dut.PC !== 32'h0) begin errors++; $display("FAIL step_pc0: got %h expected %h", dut.PC, 32'h0); end
        run(1);
        checks++;
        if (dut.PC !== 32'h4) begin errors++; $display("FAIL step_pc4: got %h expected %h", dut.PC, 32'h4); end
        run(1);
        checks++;
        if (dut.PC !== 32'h8) begin errors++; $display("FAIL step_pc8: got %h expected %h", dut.PC, 32'h8); end
    endtask

    task test_alu;
        logic [31:0] exp_v [0:13];
        int          sel [0:13];
        clear_prog();
        prog[0]  = 32'h34011234;  // ori  $1,$0,0x1234
        prog[1]  = 32'h2022FFFC;  // addi $2,$1,-4
        prog[2]  = 32'h00221823;  // subu $3,$1,$2
        prog[3]  = 32'h0041202A;  // slt  $4,$2,$1
        prog[4]  = 32'h00012900;  // sll  $5,$1,4
        prog[5]  = 32'h20000007;  // addi $0,$0,7
        prog[6]  = 32'h3C068000;  // lui  $6,0x8000
        prog[7]  = 32'h00065103;  // sra  $10,$6,4
        prog[8]  = 32'h0026582B;  // sltu $11,$1,$6
        prog[9]  = 32'h0026602A;  // slt  $12,$1,$6
        prog[10] = 32'h00006827;  // nor  $13,$0,$0
        prog[11] = 32'h0800000B;  // j    0x2C
        load_prog();
        apply_reset();
        run(11);
        checks++;
        if (dut.PC !== 32'h2C) begin errors++; $display("FAIL alu_pc: got %h expected %h", dut.PC, 32'h2C); end
        sel[0] = 1;  exp_v[0] = 32'h00001234;
        sel[1] = 2;  exp_v[1] = 32'h00001230;
        sel[2] = 3;  exp_v[2] = 32'h00000004;
        sel[3] = 4;  exp_v[3] = 32'h00000001;
        sel[4] = 5;  exp_v[4] = 32'h00012340;
        sel[5] = 0;  exp_v[5] = 32'h00000000;
        sel[6] = 6;  exp_v[6] = 32'h80000000;
        sel[7] = 10; exp_v[7] = 32'hF8000000;
        sel[8] = 11; exp_v[8] = 32'h00000001;
        sel[9] = 12; exp_v[9] = 32'h00000000;
        sel[10] = 13; exp_v[10] = 32'hFFFFFFFF;
        for (int k = 0; k < 11; k++) begin
            get_reg(sel[k], v);
            checks++;
            if (v !== exp_v[k]) begin errors++; $display("FAIL alu_reg%0d: got %h expected %h", sel[k], v, exp_v[k]); end
        end
        checks++;
        if (dut.U_SCPU.U_RF.rf[0] !== 32'h0) begin
            errors++; $display("FAIL rf0_hardwired: got %h expected %h", dut.U_SCPU.U_RF.rf[0], 32'h0);
        end
    endtask

    task test_mem;
        clear_prog();
        prog[0] = 32'h3C068000;  // lui $6,0x8000
        prog[1] = 32'hAC060008;  // sw  $6,8($0)
        prog[2] = 32'h8C070008;  // lw  $7,8($0)
        prog[3] = 32'h8C0E000A;  // lw  $14,10($0)  (low address bits ignored)
        prog[4] = 32'h340F0010;  // ori $15,$0,0x10
        prog[5] = 32'h8DF0FFF8;  // lw  $16,-8($15)
        prog[6] = 32'h08000006;  // j   0x18
        load_prog();
        apply_reset();
        run(6);
        checks++;
        if (dut.U_DM.RAM[2] !== 32'h80000000) begin
            errors++; $display("FAIL mem_word2: got %h expected %h", dut.U_DM.RAM[2], 32'h80000000);
        end
        get_reg(7, v);
        checks++;
        if (v !== 32'h80000000) begin errors++; $display("FAIL lw_rf7: got %h expected %h", v, 32'h80000000); end
        get_reg(14, v);
        checks++;
        if (v !== 32'h80000000) begin errors++; $display("FAIL lw_unaligned_rf14: got %h expected %h", v, 32'h80000000); end
        get_reg(16, v);
        checks++;
        if (v !== 32'h80000000) begin errors++; $display("FAIL lw_negoff_rf16: got %h expected %h", v, 32'h80000000); end
    endtask

    task test_branch_loop;
        int cyc;
        clear_prog();
        prog[0]  = 32'h34080000;  // ori  $8,$0,0
        prog[1]  = 32'h34090005;  // ori  $9,$0,5
        prog[2]  = 32'h21080001;  // loop: addi $8,$8,1
        prog[3]  = 32'h1509FFFE;  // bne  $8,$9,loop
        prog[4]  = 32'h1000000D;  // beq  $0,$0,0x48
        prog[18] = 32'h08000012;  // j    0x48
        load_prog();
        apply_reset();
        cyc = 0;
        while (dut.PC !== 32'h48 && cyc < 100) begin
            run(1);
            cyc++;
        end
        checks++;
        if (cyc >= 100) begin errors++; $display("FAIL loop_timeout: pc %h never reached %h", dut.PC, 32'h48); end
        checks++;
        if (cyc != 13) begin errors++; $display("FAIL loop_cycles: got %0d expected %0d", cyc, 13); end
        get_reg(8, v);
        checks++;
        if (v !== 32'h5) begin errors++; $display("FAIL loop_rf8: got %h expected %h", v, 32'h5); end
        run(3);
        checks++;
        if (dut.PC !== 32'h48) begin errors++; $display("FAIL self_loop_pc: got %h expected %h", dut.PC, 32'h48); end
    endtask

    task test_jal_jr;
        clear_prog();
        prog[0]  = 32'h34010055;  // ori  $1,$0,0x55
        prog[1]  = 32'h0C000010;  // jal  0x40
        prog[2]  = 32'h34020066;  // ori  $2,$0,0x66
        prog[3]  = 32'h34040050;  // ori  $4,$0,0x50
        prog[4]  = 32'h00802809;  // jalr $5,$4
        prog[16] = 32'h34030077;  // ori  $3,$0,0x77
        prog[17] = 32'h03E00008;  // jr   $31
        prog[20] = 32'h08000014;  // j    0x50
        load_prog();
        apply_reset();
        run(2);
        checks++;
        if (dut.PC !== 32'h40) begin errors++; $display("FAIL jal_target: got %h expected %h", dut.PC, 32'h40); end
        get_reg(31, v);
        checks++;
        if (v !== 32'h8) begin errors++; $display("FAIL jal_rf31: got %h expected %h", v, 32'h8); end
        run(2);
        checks++;
        if (dut.PC !== 32'h8) begin errors++; $display("FAIL jr_return: got %h expected %h", dut.PC, 32'h8); end
        run(3);
        checks++;
        if (dut.PC !== 32'h50) begin errors++; $display("FAIL jalr_target: got %h expected %h", dut.PC, 32'h50); end
        get_reg(5, v);
        checks++;
        if (v !== 32'h14) begin errors++; $display("FAIL jalr_rd: got %h expected %h", v, 32'h14); end
        get_reg(2, v);
        checks++;
        if (v !== 32'h66) begin errors++; $display("FAIL after_return_rf2: got %h expected %h", v, 32'h66); end
        get_reg(3, v);
        checks++;
        if (v !== 32'h77) begin errors++; $display("FAIL subroutine_rf3: got %h expected %h", v, 32'h77); end
    endtask

    task test_undefined;
        clear_prog();
        prog[0] = 32'hFC011234;  // undefined opcode with rt=1
        prog[1] = 32'h0000183F;  // undefined funct with rd=3
        prog[2] = 32'h08000002;  // j 0x8
        load_prog();
        apply_reset();
        run(1);
        checks++;
        if (dut.PC !== 32'h4) begin errors++; $display("FAIL undef_op_pc: got %h expected %h", dut.PC, 32'h4); end
        run(1);
        checks++;
        if (dut.PC !== 32'h8) begin errors++; $display("FAIL undef_funct_pc: got %h expected %h", dut.PC, 32'h8); end
        get_reg(1, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL undef_op_rf1: got %h expected %h", v, 32'h0); end
        get_reg(3, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL undef_funct_rf3: got %h expected %h", v, 32'h0); end
    endtask

    task test_hilo;
        logic [31:0] exp3, exp4;
        clear_prog();
        prog[0] = 32'h3404BEEF;  // ori  $4,$0,0xBEEF
        prog[1] = 32'h3C010001;  // lui  $1,1
        prog[2] = 32'h3C020001;  // lui  $2,1
        prog[3] = 32'h00220018;  // mult $1,$2
        prog[4] = 32'h00001810;  // mfhi $3
        prog[5] = 32'h00002012;  // mflo $4
        prog[6] = 32'h08000006;  // j    0x18
        load_prog();
        apply_reset();
        run(6);
`ifdef SCCOMP_HILO_EN
        exp3 = 32'h1;
        exp4 = 32'h0;
        checks++;
        if (dut.U_SCPU.U_RF.hi !== 32'h1) begin errors++; $display("FAIL mult_hi: got %h expected %h", dut.U_SCPU.U_RF.hi, 32'h1); end
        checks++;
        if (dut.U_SCPU.U_RF.lo !== 32'h0) begin errors++; $display("FAIL mult_lo: got %h expected %h", dut.U_SCPU.U_RF.lo, 32'h0); end
`else
        exp3 = 32'h0;
        exp4 = 32'h0000BEEF;
`endif
        checks++;
        if (dut.PC !== 32'h18) begin errors++; $display("FAIL hilo_pc: got %h expected %h", dut.PC, 32'h18); end
        get_reg(3, v);
        checks++;
        if (v !== exp3) begin errors++; $display("FAIL mfhi_rf3: got %h expected %h", v, exp3); end
        get_reg(4, v);
        checks++;
        if (v !== exp4) begin errors++; $display("FAIL mflo_rf4: got %h expected %h", v, exp4); end
    endtask

    initial begin
        rstn    = 1'b1;
        reg_sel = 5'd0;
        test_reset();
        test_alu();
        test_mem();
        test_branch_loop();
        test_jal_jr();
        test_undefined();
        test_hilo();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
